// File: rtl/instr_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit.
package instr_fetch_unit_pkg;

    localparam int unsigned XLEN = 32;

    // Byte stride between consecutive instruction words.
    localparam logic [XLEN-1:0] PC_INC = 32'd4;

    typedef enum logic [1:0] {
        StResetWait = 2'd0,
        StRun       = 2'd1,
        StFault     = 2'd2
    } ifu_state_e;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Fetch buffer: small FIFO of {instr, pc} entries with a synchronous flush.
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_buffer
    import instr_fetch_unit_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CntW = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            push,
    input  fetch_entry_t    push_data,
    input  logic            pop,
    output fetch_entry_t    head,
    output logic [CntW-1:0] count
);

    fetch_entry_t    mem_q [DEPTH];
    logic [PtrW-1:0] wr_ptr_q;
    logic [PtrW-1:0] rd_ptr_q;
    logic [CntW-1:0] count_q;
    logic            empty;
    logic            full;
    logic            push_ok;
    logic            pop_ok;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CntW'(DEPTH));
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign head    = mem_q[rd_ptr_q];
    assign count   = count_q;

    // Pointer and occupancy tracking; flush empties the buffer at the next edge.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            unique case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Entry storage; contents are only observed through a valid head.
    always_ff @(posedge clk) begin
        if (push_ok && !flush && !reset) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: credit-limited requests to instruction memory, in-order
// response buffering, and redirect handling that discards stale responses.
// Optional macro IFU_MISALIGN_TRAP_EN: a misaligned redirect target enters a sticky
// fault state instead of being silently word-aligned.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [XLEN-1:0] if_instr,
    output logic [XLEN-1:0] if_pc,
    output logic            fault
);

    localparam int unsigned CntW  = $clog2(BUF_DEPTH + 1);
    localparam int unsigned CntW1 = CntW + 1;

    ifu_state_e      state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] resp_pc_q, resp_pc_d;
    logic [CntW-1:0] outstanding_q, outstanding_d;
    logic [CntW-1:0] drop_q, drop_d;
    logic [CntW-1:0] buf_count;
    logic [CntW:0]   inflight;
    logic [XLEN-1:0] target_pc;
    logic            misaligned;
    logic            trap_en;
    logic            redirect_take;
    logic            trap;
    logic            accepted;
    logic            resp_live;
    logic            resp_drop;
    logic            push;
    logic            pop;
    fetch_entry_t    push_entry;
    fetch_entry_t    head_entry;

`ifdef IFU_MISALIGN_TRAP_EN
    assign trap_en    = 1'b1;
    assign target_pc  = redirect_pc;
    assign misaligned = (redirect_pc[1:0] != 2'b00);
`else
    assign trap_en    = 1'b0;
    assign target_pc  = redirect_pc & ~32'd3;
    assign misaligned = 1'b0;
`endif

    assign redirect_take = redirect && (state_q != StFault);
    assign trap          = redirect_take && misaligned;
    assign accepted      = imem_req && imem_gnt;
    // With nothing outstanding a response is stale (e.g. from before reset): ignore it.
    assign resp_live     = imem_rvalid && (outstanding_q != '0);
    assign resp_drop     = resp_live && (drop_q != '0);
    assign push          = resp_live && (drop_q == '0) && !redirect_take;
    assign pop           = if_valid && if_ready;

    // Credit counts the slot freed by this cycle's pop so streaming has no bubbles.
    assign inflight = {1'b0, outstanding_q} + {1'b0, buf_count} - {{CntW{1'b0}}, pop};

    assign imem_addr        = fetch_pc_q;
    assign push_entry.instr = imem_rdata;
    assign push_entry.pc    = resp_pc_q;
    assign if_instr         = if_valid ? head_entry.instr : '0;
    assign if_pc            = if_valid ? head_entry.pc : '0;

    fetch_buffer #(
        .DEPTH(BUF_DEPTH)
    ) u_fetch_buffer (
        .clk      (clk),
        .reset    (reset),
        .flush    (redirect_take),
        .push     (push),
        .push_data(push_entry),
        .pop      (pop),
        .head     (head_entry),
        .count    (buf_count)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= StResetWait;
        else       state_q <= state_d;
    end

    // FSM next state; FAULT is sticky until reset.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StResetWait: state_d = trap ? StFault : StRun;
            StRun:       if (trap) state_d = StFault;
            StFault:     state_d = StFault;
            default:     state_d = StResetWait;
        endcase
    end

    // FSM outputs: requests only in RUN, never during a redirect, and within credit.
    always_comb begin
        imem_req = 1'b0;
        if_valid = 1'b0;
        fault    = 1'b0;
        unique case (state_q)
            StRun: begin
                imem_req = !redirect && (inflight < CntW1'(BUF_DEPTH));
                if_valid = (buf_count != '0);
            end
            StResetWait: if_valid = (buf_count != '0);
            StFault:     fault    = trap_en;
            default:     ;
        endcase
    end

    // Datapath next state: fetch PC, response PC, outstanding and discard counters.
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        resp_pc_d     = resp_pc_q;
        outstanding_d = outstanding_q + CntW'(accepted) - CntW'(resp_live);
        drop_d        = drop_q;
        if (redirect_take) begin
            fetch_pc_d = target_pc;
            resp_pc_d  = target_pc;
            // Everything still in flight after this edge belongs to the old stream.
            drop_d     = outstanding_d;
        end else begin
            if (accepted)  fetch_pc_d = fetch_pc_q + PC_INC;
            if (push)      resp_pc_d  = resp_pc_q + PC_INC;
            if (resp_drop) drop_d     = drop_q - 1'b1;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            outstanding_q <= '0;
            drop_q        <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: table of redirect scenarios plus
// hand-written streaming, stall, reset and back-to-back sequences.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        if_valid;
    logic        if_ready = 1'b1;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        fault;

    logic        gnt_en = 1'b1;
    logic        inj_rv = 1'b0;
    logic [31:0] inj_data = 32'h0;
    int unsigned lat = 1;
    logic [3:0]  pv = 4'b0;
    logic [31:0] pd [4];

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } pop_t;
    pop_t got_q[$];

    typedef struct {
        logic [31:0] target;
        int unsigned lat;
        logic [31:0] exp0;
        logic [31:0] exp1;
        logic [31:0] exp2;
    } vec_t;
    localparam int NVEC = 5;
    vec_t vecs[NVEC];

    instr_fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .BUF_DEPTH(2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_gnt   (imem_gnt),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .if_valid   (if_valid),
        .if_ready   (if_ready),
        .if_instr   (if_instr),
        .if_pc      (if_pc),
        .fault      (fault)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'h5A5A_A5A5;
    endfunction

    // Memory model: fixed latency `lat`, one response per grant, in order.
    assign imem_gnt    = gnt_en;
    assign imem_rvalid = pv[0] | inj_rv;
    assign imem_rdata  = inj_rv ? inj_data : pd[0];

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            pv[k] <= pv[k+1];
            pd[k] <= pd[k+1];
        end
        pv[3] <= 1'b0;
        if (imem_req && imem_gnt) begin
            pv[lat-1] <= 1'b1;
            pd[lat-1] <= instr_of(imem_addr);
        end
    end

    // Record every handshake delivered to decode.
    always @(negedge clk) begin
        if (!reset && if_valid && if_ready) got_q.push_back({if_pc, if_instr});
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check_pop(input string name, input int i, input logic [31:0] pc);
        check({name, "_pc"}, got_q[i].pc, pc);
        check({name, "_instr"}, got_q[i].instr, instr_of(pc));
    endtask

    task automatic wait_pops(input int n);
        int budget = 60;
        while (got_q.size() < n && budget > 0) begin
            @(posedge clk);
            #1;
            budget--;
        end
        check("pop_count", got_q.size(), n);
    endtask

    task automatic do_reset(input int cycles);
        @(posedge clk);
        #1 reset = 1'b1;
        repeat (cycles) @(posedge clk);
        #1 reset = 1'b0;
        got_q.delete();
    endtask

    // Caller must be at a negedge; leaves us just after the edge that applies it.
    task automatic redirect_to(input logic [31:0] pc);
        redirect    = 1'b1;
        redirect_pc = pc;
        #1 check_bit("redir_req_low", imem_req, 1'b0);
        @(posedge clk);
        #1 redirect = 1'b0;
        got_q.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{32'h0000_0024, 1, 32'h0000_0024, 32'h0000_0028, 32'h0000_002C};
        vecs[1] = '{32'h0000_0024, 3, 32'h0000_0024, 32'h0000_0028, 32'h0000_002C};
`ifdef IFU_MISALIGN_TRAP_EN
        vecs[2] = '{32'h0000_0060, 2, 32'h0000_0060, 32'h0000_0064, 32'h0000_0068};
`else
        vecs[2] = '{32'h0000_0026, 2, 32'h0000_0024, 32'h0000_0028, 32'h0000_002C};
`endif
        vecs[3] = '{32'hFFFF_FFF8, 1, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
        vecs[4] = '{32'h0000_0100, 2, 32'h0000_0100, 32'h0000_0104, 32'h0000_0108};

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_bit("rst_req", imem_req, 1'b0);
        check_bit("rst_valid", if_valid, 1'b0);
        check("rst_instr", if_instr, 32'h0);
        check("rst_pc", if_pc, 32'h0);
        check_bit("rst_fault", fault, 1'b0);
        check("rst_addr", imem_addr, 32'h0);

        // Streaming: one request per cycle, deliveries with no gaps.
        @(posedge clk);
        #1 reset = 1'b0;
        got_q.delete();
        @(negedge clk);
        check_bit("reset_wait_req", imem_req, 1'b0);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check_bit("stream_req", imem_req, 1'b1);
            check("stream_addr", imem_addr, 32'(4 * k));
        end
        @(posedge clk);
        #1;
        check("stream_pops", got_q.size(), 6);
        for (int i = 0; i < 6; i++) check_pop("stream", i, 32'(4 * i));

        // Decode stall: buffer fills, requests stop, head holds.
        if_ready = 1'b0;
        repeat (10) @(negedge clk);
        check_bit("stall_req", imem_req, 1'b0);
        check_bit("stall_valid", if_valid, 1'b1);
        check("stall_pc", if_pc, 32'h18);
        check("stall_instr", if_instr, instr_of(32'h18));
        @(posedge clk);
        #1 if_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check_bit("stall_progress", got_q.size() >= 14, 1'b1);
        for (int i = 0; i < got_q.size(); i++) check_pop("stall_seq", i, 32'(4 * i));

        // Table of redirect scenarios.
        for (int v = 0; v < NVEC; v++) begin
            lat = vecs[v].lat;
            do_reset(4);
            repeat (6) @(posedge clk);
            @(negedge clk);
            redirect_to(vecs[v].target);
            check("vec_addr", imem_addr, vecs[v].exp0);
            wait_pops(3);
            check_pop("vec0", 0, vecs[v].exp0);
            check_pop("vec1", 1, vecs[v].exp1);
            check_pop("vec2", 2, vecs[v].exp2);
            check_bit("vec_fault", fault, 1'b0);
        end

        // Redirect with two requests outstanding: both stale responses dropped.
        lat = 3;
        do_reset(4);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        redirect_to(32'h24);
        check("out2_addr", imem_addr, 32'h24);
        wait_pops(2);
        check_pop("out2_0", 0, 32'h24);
        check_pop("out2_1", 1, 32'h28);

        // Redirect in the cycle the request for 0x10 is presented.
        begin
            logic found;
            found = 1'b0;
            lat = 1;
            do_reset(4);
            for (int c = 0; c < 30; c++) begin
                @(negedge clk);
                if (imem_req && imem_addr == 32'h10) begin
                    found = 1'b1;
                    break;
                end
            end
            check_bit("found_0x10", found, 1'b1);
            redirect_to(32'h40);
            check("grant_redir_addr", imem_addr, 32'h40);
            wait_pops(2);
            check_pop("grant_redir0", 0, 32'h40);
            check_pop("grant_redir1", 1, 32'h44);
        end

        // Back-to-back redirects: the last one wins.
        lat = 2;
        do_reset(4);
        repeat (6) @(posedge clk);
        @(negedge clk);
        redirect    = 1'b1;
        redirect_pc = 32'h80;
        @(posedge clk);
        #1 redirect_pc = 32'hA0;
        check_bit("b2b_req_low", imem_req, 1'b0);
        @(posedge clk);
        #1 redirect = 1'b0;
        got_q.delete();
        check("b2b_addr", imem_addr, 32'hA0);
        wait_pops(2);
        check_pop("b2b0", 0, 32'hA0);
        check_pop("b2b1", 1, 32'hA4);

        // Mid-stream reset: in-flight and junk responses before the first grant ignored.
        lat = 2;
        do_reset(4);
        repeat (8) @(posedge clk);
        do_reset(1);
        inj_rv   = 1'b1;
        inj_data = 32'hBAD0_BAD0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1 inj_rv = 1'b0;
        wait_pops(2);
        check_pop("mid_rst0", 0, 32'h0);
        check_pop("mid_rst1", 1, 32'h4);

`ifdef IFU_MISALIGN_TRAP_EN
        // Misaligned redirect traps until reset.
        lat = 1;
        do_reset(4);
        repeat (5) @(posedge clk);
        @(negedge clk);
        redirect_to(32'h26);
        repeat (5) @(negedge clk);
        check_bit("trap_fault", fault, 1'b1);
        check_bit("trap_req", imem_req, 1'b0);
        check_bit("trap_valid", if_valid, 1'b0);
        do_reset(2);
        @(negedge clk);
        check_bit("trap_cleared", fault, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
